// File: rtl/rec_quant_pkg.sv
// Shared constants and types for the quantise / dequantise datapath:
// transform-size encodings, the beats-per-block table and datapath widths.
package rec_quant_pkg;

  localparam int DATA_W  = 16;
  localparam int COEF_W  = 16;
  localparam int OFF_W   = 28;
  localparam int ACC_W   = 34;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    DCT_4  = 2'b00,
    DCT_8  = 2'b01,
    DCT_16 = 2'b10,
    DCT_32 = 2'b11
  } transize_e;

  localparam logic [CNT_W:0] BEATS_PER_BLOCK [4] = '{9'd4, 9'd16, 9'd64, 9'd256};

  // Index of the final beat of a block; fits the 8-bit beat counter.
  function automatic logic [CNT_W-1:0] last_beat(input transize_e t);
    logic [CNT_W:0] b;
    b = BEATS_PER_BLOCK[t] - 1'b1;
    return b[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rec_quant_lane.sv
// One coefficient lane: multiply in stage 1, add offset / shift / clip in
// stage 2. Forward mode works on magnitude and reapplies the sign.
module rec_quant_lane
  import rec_quant_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_p0,
  input  logic                      en_p1,
  input  logic                      inverse,
  input  logic signed [DATA_W-1:0]  coef,
  input  logic signed [COEF_W-1:0]  q_data,
  input  logic signed [OFF_W-1:0]   offset,
  input  logic [SHIFT_W-1:0]        shift,
  output logic signed [DATA_W-1:0]  res_p2
);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [ACC_W:0] fwd_round(
    input logic signed [ACC_W-1:0] sum,
    input logic [SHIFT_W-1:0]      sh,
    input logic                    neg
  );
    logic [ACC_W-1:0]        lvl;
    logic signed [ACC_W:0]   mag;
    lvl = sum >> sh;
    mag = $signed({1'b0, lvl});
    return neg ? -mag : mag;
  endfunction

  function automatic logic signed [ACC_W:0] inv_round(
    input logic signed [ACC_W-1:0] sum,
    input logic [SHIFT_W-1:0]      sh
  );
    logic signed [ACC_W-1:0] t;
    t = sum >>> sh;
    return {t[ACC_W-1], t};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W:0] v);
    if (v > SAT_MAX)
      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN)
      return SAT_MIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  logic signed [DATA_W:0]   c_ext;
  logic signed [DATA_W:0]   mag_ext;
  logic signed [DATA_W:0]   opnd;
  logic signed [ACC_W-1:0]  prod_p0;

  always_comb begin
    c_ext   = coef;
    mag_ext = c_ext[DATA_W] ? -c_ext : c_ext;
    opnd    = inverse ? c_ext : mag_ext;
    prod_p0 = ACC_W'(opnd) * ACC_W'(q_data);
  end

  // ---- stage 1: product and per-beat quant parameters
  logic signed [ACC_W-1:0]  prod_p1;
  logic                     neg_p1;
  logic                     inv_p1;
  logic signed [OFF_W-1:0]  off_p1;
  logic [SHIFT_W-1:0]       shift_p1;

  always_ff @(posedge clk) begin
    if (en_p0) begin
      prod_p1  <= prod_p0;
      neg_p1   <= coef[DATA_W-1];
      inv_p1   <= inverse;
      off_p1   <= offset;
      shift_p1 <= shift;
    end
  end

  logic signed [ACC_W-1:0]  sum_p1;
  logic signed [DATA_W-1:0] res_nxt;

  always_comb begin
    sum_p1  = prod_p1 + ACC_W'(off_p1);
    res_nxt = sat(inv_p1 ? inv_round(sum_p1, shift_p1)
                         : fwd_round(sum_p1, shift_p1, neg_p1));
  end

  // ---- stage 2: clipped result, held while no beat is in flight
  always_ff @(posedge clk) begin
    if (!rst)
      res_p2 <= '0;
    else if (en_p1)
      res_p2 <= res_nxt;
  end

endmodule

// File: rtl/rec_quant.sv
// Quantiser / dequantiser top: LANES coefficient lanes with a fixed 2-cycle
// latency, block beat counter and coded-block flag accumulation.
module rec_quant
  import rec_quant_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic                       inverse,
  input  logic [1:0]                 i_transize,
  input  logic [DATA_W*LANES-1:0]    i_data,
  input  logic signed [COEF_W-1:0]   q_data,
  input  logic signed [OFF_W-1:0]    offset,
  input  logic [SHIFT_W-1:0]         shift,
  output logic                       o_valid,
  output logic [DATA_W*LANES-1:0]    o_data,
  output logic                       o_last,
  output logic                       o_cbf
);

  logic [CNT_W-1:0] cnt;
  transize_e        size_lat;
  transize_e        size_cur;
  logic             last_p0;

  // The size presented with the first beat governs the whole block.
  always_comb begin
    size_cur = (cnt == '0) ? transize_e'(i_transize) : size_lat;
    last_p0  = (cnt == last_beat(size_cur));
  end

  logic vld_p1, last_p1;
  logic vld_p2, last_p2;
  logic cbf_acc;
  logic nz_p2;

  assign nz_p2 = |o_data;

  // ---- stage 1 / stage 2 control, beat counter and cbf accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      size_lat <= DCT_4;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      vld_p2   <= 1'b0;
      last_p2  <= 1'b0;
      cbf_acc  <= 1'b0;
    end else begin
      vld_p1  <= i_valid;
      last_p1 <= i_valid & last_p0;
      vld_p2  <= vld_p1;
      last_p2 <= vld_p1 & last_p1;
      if (i_valid) begin
        if (cnt == '0)
          size_lat <= size_cur;
        cnt <= last_p0 ? '0 : cnt + 1'b1;
      end
      if (vld_p2)
        cbf_acc <= last_p2 ? 1'b0 : (cbf_acc | nz_p2);
    end
  end

  assign o_valid = vld_p2;
  assign o_last  = vld_p2 & last_p2;
  assign o_cbf   = vld_p2 & last_p2 & (cbf_acc | nz_p2);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rec_quant_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .en_p0   (i_valid),
      .en_p1   (vld_p1),
      .inverse (inverse),
      .coef    (i_data[l*DATA_W +: DATA_W]),
      .q_data  (q_data),
      .offset  (offset),
      .shift   (shift),
      .res_p2  (o_data[l*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/rec_quant.md
REC_QUANT -- requirements
Module: rec_quant

Interface
REQ-001 LANES parameter, default 4; number of coefficients processed per beat (legal: 4 only in this revision).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 i_valid  input  1  beat of LANES coefficients present.
REQ-005 inverse  input  1  0 = forward quantisation, 1 = dequantisation.
REQ-006 i_transize  input  2  00=4x4, 01=8x8, 10=16x16, 11=32x32; sampled on first beat of a block.
REQ-007 i_data  input  16*LANES  signed coefficients, lane 0 in LSBs.
REQ-008 q_data  input  16  signed scale from quant-parameter stage.
REQ-009 offset  input  28  signed rounding offset from quant-parameter stage.
REQ-010 shift  input  5  right-shift amount from quant-parameter stage.
REQ-011 o_valid  output  1  o_data beat valid.
REQ-012 o_data  output  16*LANES  signed quantised levels / reconstructed coefficients.
REQ-013 o_last  output  1  high with the final output beat of a block.
REQ-014 o_cbf  output  1  valid with o_last; 1 if any o_data lane in the block is nonzero.

Function
REQ-015 Fixed 2-cycle latency: beat accepted at edge N appears on o_valid/o_data after edge N+2; no backpressure, one beat per cycle sustained.
REQ-016 Stage 1 registers per-lane product, sign, inverse, offset, shift, last flag; stage 2 registers rounded, shifted, clipped result.
REQ-017 Forward: level = (|c| * q_data + offset) >> shift (logical), output = sign(c) ? -level : level.
REQ-018 Inverse: r = (c * q_data + offset) >>> shift (arithmetic, floor toward minus infinity).
REQ-019 Intermediate arithmetic 34-bit signed; no overflow for any legal input.
REQ-020 Both modes clip result to [-32768, 32767] before registering.
REQ-021 q_data/offset/shift/inverse are sampled with each beat in stage 1; changes between beats take effect on the next beat.
REQ-022 Beats per block: 4x4=4, 8x8=16, 16x16=64, 32x32=256; 8-bit beat counter, wraps to 0 after last beat.
REQ-023 i_transize latched when counter=0 and i_valid=1; changes mid-block ignored until next block.
REQ-024 Cycles with i_valid=0 do not advance counter; gaps inside a block allowed.
REQ-025 o_cbf accumulates OR of nonzero lanes across block beats, including last beat; accumulator clears after the o_last beat.
REQ-026 o_data holds last value when o_valid=0; o_last and o_cbf are 0 whenever o_valid=0.

Reset
REQ-027 rst=0 at a rising edge clears o_valid, o_last, o_cbf, o_data, pipeline valids, beat counter, cbf accumulator, latched size.
REQ-028 Reset mid-block discards in-flight beats; no o_valid for them; next accepted beat starts a new block.
REQ-029 First beat after rst release is accepted normally.

Structure
REQ-030 Shared package holds transform-size encodings (DCT_4..DCT_32), beats-per-block table, coefficient width 16, offset width 28.
REQ-031 One sub-module rec_quant_lane (single-coefficient 2-stage multiply/round/shift/clip) instantiated LANES times; counter and cbf logic in top.

Verification
REQ-032 Forward, q_data=16384, offset=87040, shift=19, lanes {1000,-1000,0,5} -> o_data {31,-31,0,0} two cycles later.
REQ-033 Inverse, q_data=64, offset=1, shift=1, lanes {10,-10,0,1} -> {320,-320,0,32}.
REQ-034 Inverse, q_data=18432, offset=8, shift=4, lanes {32767,-32768,1,-1} -> {32767,-32768,1152,-1152}.
REQ-035 4x4 forward block, 4 beats all zero with 1-cycle gap after beat 2 -> o_last on 4th output beat, o_cbf=0; repeat with one lane=1000 in beat 3 -> o_cbf=1.
REQ-036 32x32 block, rst=0 asserted after beat 100 -> no further o_valid; next 4x4 block after release -> o_last on its 4th output beat.
